// File: rtl/mult_wide_sched_pkg.sv
// Shared widths and payload types for the mult_wide_sched slice.
// Provides the DSP operand bundle (op_t) and the result tag (tag_t).
package mult_wide_sched_pkg;

    localparam int unsigned LANE_W   = 9;
    localparam int unsigned LANES    = 4;
    localparam int unsigned A_W      = 36;
    localparam int unsigned B_W      = 36;
    localparam int unsigned C_W      = 54;
    localparam int unsigned Z_W      = 54;
    localparam int unsigned ADDSUB_W = 4;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W = 3;

    // One operand set as presented to the DSP pins.
    typedef struct packed {
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
        logic [C_W-1:0]      c;
        logic [ADDSUB_W-1:0] addsub;
        logic                signd;
    } op_t;

    // Result tag travelling alongside the DSP pipeline.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_wide_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NREQ requests, searching from the
// priority pointer upward with wrap; the pointer moves past each winner.
// Ports: CLK, RST (async active-high), req (request vector),
//        gnt (one-hot grant, combinational), gnt_id (index of winner),
//        gnt_any (a grant is made this cycle).
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     gnt_any
);

    localparam int unsigned ID_W = $clog2(NREQ);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_nxt;

    // Rotating priority search: first requester at ptr, ptr+1, ... mod NREQ.
    always_comb begin
        int unsigned     sum;
        logic [ID_W-1:0] idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = 32'(ptr_q) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = ID_W'(sum);
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt_id   = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    // Pointer moves to the requester just after the winner; holds when idle.
    always_comb begin
        ptr_nxt = ptr_q;
        if (gnt_any) begin
            if (32'(gnt_id) == NREQ - 1) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = gnt_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mult_wide_sched.sv
// Shares one MULTADDSUB9X9WIDE sum-of-products DSP among NREQ requesters.
// One operand set is issued per cycle by round-robin arbitration; a tag
// pipeline matched to the DSP latency labels each Z result with its requester.
// Optional build macro MULT_WIDE_SCHED_INREG_EN: registers the DSP operand
// pins in fabric (adds one cycle of latency); otherwise pins are driven
// straight from the grant mux.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   REQ_VALID/REQ_READY      per-requester handshake (READY combinational)
//   REQ_A/B/C/ADDSUB/SIGNED  per-requester operand sets, flattened
//   DSP_A/B/C/ADDSUB/SIGNED  to the DSP operand pins
//   DSP_Z                    from the DSP output register
//   RES_VALID/RES_ID/RES_Z   tagged result stream (no backpressure)
module mult_wide_sched
    import mult_wide_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DSP_LAT = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           REQ_VALID,
    output logic [NREQ-1:0]           REQ_READY,
    input  logic [NREQ*A_W-1:0]       REQ_A,
    input  logic [NREQ*B_W-1:0]       REQ_B,
    input  logic [NREQ*C_W-1:0]       REQ_C,
    input  logic [NREQ*ADDSUB_W-1:0]  REQ_ADDSUB,
    input  logic [NREQ-1:0]           REQ_SIGNED,
    output logic [A_W-1:0]            DSP_A,
    output logic [B_W-1:0]            DSP_B,
    output logic [C_W-1:0]            DSP_C,
    output logic [ADDSUB_W-1:0]       DSP_ADDSUB,
    output logic                      DSP_SIGNED,
    input  logic [Z_W-1:0]            DSP_Z,
    output logic                      RES_VALID,
    output logic [$clog2(NREQ)-1:0]   RES_ID,
    output logic [Z_W-1:0]            RES_Z
);

    localparam int unsigned ID_W = $clog2(NREQ);
`ifdef MULT_WIDE_SCHED_INREG_EN
    localparam int unsigned IN_STG = 1;
`else
    localparam int unsigned IN_STG = 0;
`endif
    localparam int unsigned LAT = DSP_LAT + IN_STG;

    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    op_t             op_mux;
    op_t             op_out;
    tag_t            tag_in;
    tag_t            tag_q [LAT];
    logic            unused_tag_id;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (REQ_VALID),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign REQ_READY = gnt;

    // Operand select; an idle cycle leaves every pin at zero.
    always_comb begin
        op_mux = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_mux.a      = REQ_A[i*A_W +: A_W];
                op_mux.b      = REQ_B[i*B_W +: B_W];
                op_mux.c      = REQ_C[i*C_W +: C_W];
                op_mux.addsub = REQ_ADDSUB[i*ADDSUB_W +: ADDSUB_W];
                op_mux.signd  = REQ_SIGNED[i];
            end
        end
    end

`ifdef MULT_WIDE_SCHED_INREG_EN
    // Fabric operand stage; reloads every cycle so idle cycles zero it.
    op_t op_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q <= '0;
        end else begin
            op_q <= op_mux;
        end
    end
    assign op_out = op_q;
`else
    assign op_out = op_mux;
`endif

    assign DSP_A      = op_out.a;
    assign DSP_B      = op_out.b;
    assign DSP_C      = op_out.c;
    assign DSP_ADDSUB = op_out.addsub;
    assign DSP_SIGNED = op_out.signd;

    assign tag_in = '{valid: gnt_any, id: TAG_ID_W'(gnt_id)};

    // Tag shift register, one entry per cycle, depth equal to total latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign RES_VALID = tag_q[LAT-1].valid;
    assign RES_ID    = tag_q[LAT-1].id[ID_W-1:0];
    assign RES_Z     = DSP_Z;

    // Upper id bits are spare when NREQ is below the tag's capacity.
    assign unused_tag_id = ^tag_q[LAT-1].id;

endmodule

// File: tb/tb_mult_wide_sched.sv
// Directed self-checking bench for mult_wide_sched with a behavioural
// MULTADDSUB9X9WIDE model (output register only) closing the DSP loop.
module tb_mult_wide_sched;

    localparam int NREQ    = 4;
    localparam int DSP_LAT = 1;
`ifdef MULT_WIDE_SCHED_INREG_EN
    localparam int PIN_DLY = 1;
`else
    localparam int PIN_DLY = 0;
`endif
    localparam int L = DSP_LAT + PIN_DLY;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ-1:0]      REQ_READY;
    logic [NREQ*36-1:0]   REQ_A;
    logic [NREQ*36-1:0]   REQ_B;
    logic [NREQ*54-1:0]   REQ_C;
    logic [NREQ*4-1:0]    REQ_ADDSUB;
    logic [NREQ-1:0]      REQ_SIGNED;
    logic [35:0]          DSP_A;
    logic [35:0]          DSP_B;
    logic [53:0]          DSP_C;
    logic [3:0]           DSP_ADDSUB;
    logic                 DSP_SIGNED;
    logic [53:0]          DSP_Z;
    logic                 RES_VALID;
    logic [1:0]           RES_ID;
    logic [53:0]          RES_Z;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mult_wide_sched #(
        .NREQ    (NREQ),
        .DSP_LAT (DSP_LAT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .REQ_C      (REQ_C),
        .REQ_ADDSUB (REQ_ADDSUB),
        .REQ_SIGNED (REQ_SIGNED),
        .DSP_A      (DSP_A),
        .DSP_B      (DSP_B),
        .DSP_C      (DSP_C),
        .DSP_ADDSUB (DSP_ADDSUB),
        .DSP_SIGNED (DSP_SIGNED),
        .DSP_Z      (DSP_Z),
        .RES_VALID  (RES_VALID),
        .RES_ID     (RES_ID),
        .RES_Z      (RES_Z)
    );

    // Sum of four 9x9 products (added when the ADDSUB bit is 1) plus C.
    function automatic logic [53:0] dsp_f(input logic [35:0] a, input logic [35:0] b,
                                          input logic [53:0] c, input logic [3:0] as,
                                          input logic sg);
        longint s;
        longint ea;
        longint eb;
        logic [8:0] la;
        logic [8:0] lb;
        s = longint'(c);
        for (int k = 0; k < 4; k++) begin
            la = a[k*9 +: 9];
            lb = b[k*9 +: 9];
            ea = sg ? longint'($signed(la)) : longint'(la);
            eb = sg ? longint'($signed(lb)) : longint'(lb);
            if (as[k]) s = s + ea * eb;
            else       s = s - ea * eb;
        end
        return s[53:0];
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) DSP_Z <= '0;
        else     DSP_Z <= dsp_f(DSP_A, DSP_B, DSP_C, DSP_ADDSUB, DSP_SIGNED);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic set_req(input int i, input logic [35:0] a, input logic [35:0] b,
                           input logic [53:0] c, input logic [3:0] as, input logic sg);
        REQ_A[i*36 +: 36]     = a;
        REQ_B[i*36 +: 36]     = b;
        REQ_C[i*54 +: 54]     = c;
        REQ_ADDSUB[i*4 +: 4]  = as;
        REQ_SIGNED[i]         = sg;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g3 [4];
        int gexp;
        int gpin;
        int r;
        logic [3:0] v;
        logic [3:0] rdy;
        g3 = '{1, 3, 1, 3};

        RST        = 1'b1;
        REQ_VALID  = '0;
        REQ_A      = '0;
        REQ_B      = '0;
        REQ_C      = '0;
        REQ_ADDSUB = '0;
        REQ_SIGNED = '0;

        // Reset values
        mid();
        chk("rst_ready", 64'(REQ_READY), 64'h0);
        chk("rst_dsp_a", 64'(DSP_A), 64'h0);
        chk("rst_dsp_c", 64'(DSP_C), 64'h0);
        chk("rst_res_valid", 64'(RES_VALID), 64'h0);
        chk("rst_res_id", 64'(RES_ID), 64'h0);
        next_cycle();
        RST = 1'b0;

        // Single request from requester 2: 3*5 = 15
        set_req(2, 36'd3, 36'd5, 54'd0, 4'hF, 1'b1);
        REQ_VALID = 4'b0100;
        mid();
        chk("t1_ready", 64'(REQ_READY), 64'h4);
        chk("t1_res_valid_early", 64'(RES_VALID), 64'h0);
`ifndef MULT_WIDE_SCHED_INREG_EN
        chk("t1_dsp_a", 64'(DSP_A), 64'd3);
        chk("t1_dsp_b", 64'(DSP_B), 64'd5);
        chk("t1_dsp_addsub", 64'(DSP_ADDSUB), 64'hF);
        chk("t1_dsp_signed", 64'(DSP_SIGNED), 64'h1);
`endif
        next_cycle();
        REQ_VALID = 4'b0000;
`ifdef MULT_WIDE_SCHED_INREG_EN
        mid();
        chk("t1_dsp_a", 64'(DSP_A), 64'd3);
        chk("t1_dsp_b", 64'(DSP_B), 64'd5);
        chk("t1_dsp_addsub", 64'(DSP_ADDSUB), 64'hF);
        chk("t1_dsp_signed", 64'(DSP_SIGNED), 64'h1);
        chk("t1_res_valid_mid", 64'(RES_VALID), 64'h0);
        next_cycle();
`endif
        mid();
        chk("t1_res_valid", 64'(RES_VALID), 64'h1);
        chk("t1_res_id", 64'(RES_ID), 64'd2);
        chk("t1_res_z", 64'(RES_Z), 64'd15);
        chk("t1_idle_dsp_a", 64'(DSP_A), 64'h0);
        chk("t1_idle_signed", 64'(DSP_SIGNED), 64'h0);
        next_cycle();

        // All four valid for 8 cycles from reset: grants 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 36'(i + 1), 36'd1, 54'd0, 4'hF, 1'b0);
        for (int c = 0; c < 9 + L; c++) begin
            REQ_VALID = (c < 8) ? 4'hF : 4'h0;
            mid();
            rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
            chk("t2_ready", 64'(REQ_READY), 64'(rdy));
            r = (c >= L && c - L < 8) ? (c - L) % 4 : -1;
            chk("t2_res_valid", 64'(RES_VALID), 64'(r >= 0));
            if (r >= 0) begin
                chk("t2_res_id", 64'(RES_ID), 64'(r));
                chk("t2_res_z", 64'(RES_Z), 64'(r + 1));
            end
            next_cycle();
        end

        // Requester 1 alone (pointer -> 2), then 1 and 3 together: 3, 1, 3
        for (int c = 0; c < 5 + L; c++) begin
            if (c == 0)      v = 4'b0010;
            else if (c < 4)  v = 4'b1010;
            else             v = 4'b0000;
            REQ_VALID = v;
            mid();
            gexp = (c < 4) ? g3[c] : -1;
            chk("t3_ready", 64'(REQ_READY), (gexp >= 0) ? 64'(1 << gexp) : 64'h0);
            gpin = (c >= PIN_DLY && c - PIN_DLY < 4) ? g3[c - PIN_DLY] : -1;
            chk("t3_dsp_a", 64'(DSP_A), (gpin >= 0) ? 64'(gpin + 1) : 64'h0);
            r = (c >= L && c - L < 4) ? g3[c - L] : -1;
            chk("t3_res_valid", 64'(RES_VALID), 64'(r >= 0));
            if (r >= 0) begin
                chk("t3_res_id", 64'(RES_ID), 64'(r));
                chk("t3_res_z", 64'(RES_Z), 64'(r + 1));
            end
            next_cycle();
        end

        // Signed: -1*2 + 10 = 8 (requester 0, pointer at 0)
        set_req(0, 36'h1FF, 36'd2, 54'd10, 4'hF, 1'b1);
        REQ_VALID = 4'b0001;
        mid();
        chk("t4_ready", 64'(REQ_READY), 64'h1);
        next_cycle();
        REQ_VALID = 4'b0000;
        repeat (L - 1) next_cycle();
        mid();
        chk("t4_res_valid", 64'(RES_VALID), 64'h1);
        chk("t4_res_id", 64'(RES_ID), 64'd0);
        chk("t4_res_z", 64'(RES_Z), 64'd8);
        next_cycle();

        // Unsigned: 511*2 = 1022 (requester 3, pointer at 1)
        set_req(3, 36'h1FF, 36'd2, 54'd0, 4'hF, 1'b0);
        REQ_VALID = 4'b1000;
        mid();
        chk("t4u_ready", 64'(REQ_READY), 64'h8);
        next_cycle();
        REQ_VALID = 4'b0000;
        repeat (L - 1) next_cycle();
        mid();
        chk("t4u_res_id", 64'(RES_ID), 64'd3);
        chk("t4u_res_z", 64'(RES_Z), 64'd1022);
        next_cycle();

        // Top lane and full-width C: 2*7 + (2^54-16) = 2^54-2
        set_req(2, 36'(2) << 27, 36'(7) << 27, 54'h3F_FFFF_FFFF_FFF0, 4'hF, 1'b0);
        REQ_VALID = 4'b0100;
        mid();
        chk("t4w_ready", 64'(REQ_READY), 64'h4);
        next_cycle();
        REQ_VALID = 4'b0000;
        repeat (L - 1) next_cycle();
        mid();
        chk("t4w_res_id", 64'(RES_ID), 64'd2);
        chk("t4w_res_z", 64'(RES_Z), 64'h3F_FFFF_FFFF_FFFE);
        next_cycle();

        // Async reset with a result in flight (pointer at 3 -> grant 1)
        REQ_VALID = 4'b0010;
        mid();
        chk("t5_ready", 64'(REQ_READY), 64'h2);
        next_cycle();
        REQ_VALID = 4'b0000;
        repeat (L - 1) next_cycle();
        #2;
        chk("t5_inflight_valid", 64'(RES_VALID), 64'h1);
        chk("t5_inflight_id", 64'(RES_ID), 64'd1);
        RST = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(RES_VALID), 64'h0);
        chk("t5_rst_id", 64'(RES_ID), 64'h0);
        next_cycle();
        RST = 1'b0;
        for (int c = 0; c < L + 2; c++) begin
            mid();
            chk("t5_post_rst_valid", 64'(RES_VALID), 64'h0);
            next_cycle();
        end
        REQ_VALID = 4'hF;
        mid();
        chk("t5_ptr0_ready", 64'(REQ_READY), 64'h1);
        next_cycle();
        REQ_VALID = 4'h0;
        repeat (L - 1) next_cycle();
        mid();
        chk("t5_res_valid", 64'(RES_VALID), 64'h1);
        chk("t5_res_id", 64'(RES_ID), 64'd0);
        chk("t5_res_z", 64'(RES_Z), 64'd8);
        next_cycle();
        mid();
        chk("t5_res_valid_end", 64'(RES_VALID), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_wide_sched.md
# mult_wide_sched

Round-robin scheduler that shares one MULTADDSUB9X9WIDE sum-of-products unit (four 9x9 products plus a 54-bit C term, output register enabled, operand registers bypassed) among NREQ requesters. It accepts one operand set per cycle through per-requester valid/ready handshakes and drives the DSP operand, ADDSUB and SIGNED pins. A fixed-latency tag pipeline returns each DSP Z result tagged with its requester ID. It sits between the requesting datapaths and the single DSP instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- DSP_LAT, 1, DSP register stages from operand pins to Z (1 = REGOUTPUT only)
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ_VALID  in  NREQ  requester i has an operand set
- REQ_READY  out  NREQ  requester i's set is issued this cycle
- REQ_A  in  NREQ*36  per requester {A3,A2,A1,A0}, 9 bits each
- REQ_B  in  NREQ*36  per requester {B3,B2,B1,B0}
- REQ_C  in  NREQ*54  per requester C term
- REQ_ADDSUB  in  NREQ*4  per requester ADDSUB pattern
- REQ_SIGNED  in  NREQ  per requester SIGNED
- DSP_A, DSP_B  out  36  to DSP A0..A3 / B0..B3
- DSP_C  out  54  to DSP C
- DSP_ADDSUB  out  4; DSP_SIGNED  out  1
- DSP_Z  in  54  from DSP Z
- RES_VALID  out  1  RES_Z/RES_ID valid this cycle
- RES_ID  out  $clog2(NREQ)  requester of this result
- RES_Z  out  54  result, equal to DSP_Z

## Operation
- Issue: at most one requester granted per cycle; grant only to i with REQ_VALID[i]=1. REQ_READY[i]=1 exactly when i granted; transfer occurs when REQ_VALID[i] & REQ_READY[i].
- Arbitration: round-robin; pointer PTR (reset 0) holds highest-priority index; search PTR, PTR+1, ... mod NREQ. After a grant to i, PTR <= (i+1) mod NREQ. No grant -> PTR unchanged.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.
- Operand mux: granted requester's A, B, C, ADDSUB, SIGNED drive DSP_* pins; idle cycle drives all DSP_* to 0 (ADDSUB=0, SIGNED=0).
- Tag pipeline: shift register of {valid, id}, depth = total latency; entry pushed every cycle (valid=0 on idle). Output stage gives RES_VALID/RES_ID.
- RES_Z = DSP_Z combinationally; meaningful only when RES_VALID=1.
- No result backpressure: consumer must accept every RES_VALID cycle.
- Requester may drop or change REQ_VALID/operands at any time while not granted; no hold requirement.

## Timing
- REQ_READY combinational from REQ_VALID and PTR (same cycle).
- Latency L = DSP_LAT (+1 with input register, see Configuration): set issued at edge t appears with RES_VALID=1 in cycle t+L.
- Throughput 1 result/cycle; back-to-back issues from same or different requesters allowed.
- Reset values: REQ_READY=0 (no valid while in reset), all DSP_*=0, RES_VALID=0, RES_ID=0, PTR=0, all tag entries invalid.
- Reset mid-operation: in-flight tags cleared immediately; those results never signalled; first post-reset issue returns after L cycles.
- Simultaneous valid from all: grant order PTR, PTR+1, ... wraps after NREQ-1 to 0.

## Configuration
- MULT_WIDE_SCHED_INREG_EN defined: DSP_* driven from registers loaded on issue cycle (zeroed on idle cycle and by RST); L = DSP_LAT+1; tag depth +1. For DSPs built with REGINPUT*="BYPASS" where timing needs an operand stage in fabric.
- Undefined: DSP_* combinational from the grant mux; L = DSP_LAT.

## Structure
- Package mult_wide_sched_pkg: A_W=36, B_W=36, C_W=54, Z_W=54, ADDSUB_W=4, LANE_W=9; tag struct {valid, id}.
- Sub-module rr_arbiter (NREQ-wide request -> one-hot grant, PTR update); mux, optional input register and tag pipeline in top.

## Test plan
- Single request: NREQ=4, DSP_LAT=1, macro off; REQ_VALID=4'b0100, A0=3,B0=5, others 0, C=0, ADDSUB=4'hF, SIGNED=1 -> REQ_READY=4'b0100 same cycle; next cycle RES_VALID=1, RES_ID=2, RES_Z=15 (from DSP model).
- All four valid continuously for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; RES_ID sequence identical, delayed L.
- Requesters 1 and 3 valid, PTR=2 -> grant 3 then 1 then 3; idle cycles produce RES_VALID=0 and DSP_*=0.
- Signed operands A0=-1 (9'h1FF), B0=2, SIGNED=1, C=10 -> RES_Z=8, RES_ID correct.
- RST asserted asynchronously with 1 result in flight -> RES_VALID falls immediately, no result after release; PTR=0; new issue returns after L.
- Macro on: single issue at edge t -> DSP_* change at t+1, RES_VALID at t+2; consecutive issues keep 1/cycle throughput.
